load_store_queue: RTL and testbench

In-order load/store queue that sits directly upstream of `memory_unit` in the out-of-order core. It accepts memory operations from dispatch/issue with their ROB tag and serialises them to the memory unit, one request in flight at a time. It matches returned load data and broadcasts completions, loads and stores alike, on the common data bus (CDB). Program order of all memory accesses is preserved.

---
 rtl/load_store_queue_pkg.sv | 33 +++
 rtl/load_store_queue_if.sv | 42 ++++
 rtl/load_store_queue_fifo.sv | 47 ++++
 rtl/load_store_queue.sv | 156 +++++++++++++++
 tb/tb_load_store_queue.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared definitions for the load/store queue: FSM states and queue entry layout.
package load_store_queue_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LD = 2'd1,
        WAIT_ST = 2'd2,
        DRAIN   = 2'd3
    } lsq_state_t;

    // Queue entry packing, MSB to LSB: {store, tag, address, data}
    function automatic int unsigned entry_addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned entry_tag_lsb(input int unsigned data_w,
                                                  input int unsigned addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int unsigned entry_store_bit(input int unsigned data_w,
                                                    input int unsigned addr_w,
                                                    input int unsigned tag_w);
        return data_w + addr_w + tag_w;
    endfunction

    function automatic int unsigned entry_width(input int unsigned data_w,
                                                input int unsigned addr_w,
                                                input int unsigned tag_w);
        return data_w + addr_w + tag_w + 1;
    endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// Enqueue, memory-unit and CDB signal bundle for the load/store queue.
// slave = the queue itself, master = the surrounding core / memory unit.
interface load_store_queue_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned TAG_BITS     = 4,
    parameter int unsigned DEPTH        = 8
);
    logic                      enq_valid;
    logic                      enq_store;
    logic [TAG_BITS-1:0]       enq_tag;
    logic [ADDRESS_BITS-1:0]   enq_address;
    logic [DATA_WIDTH-1:0]     enq_data;
    logic                      enq_ready;
    logic [$clog2(DEPTH):0]    count;
    logic                      flush;
    logic                      mem_load;
    logic                      mem_store;
    logic [ADDRESS_BITS-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]     mem_store_data;
    logic                      mem_ready;
    logic                      mem_valid_load;
    logic [ADDRESS_BITS-1:0]   mem_data_addr;
    logic [DATA_WIDTH-1:0]     mem_load_data;
    logic                      cdb_valid;
    logic [TAG_BITS-1:0]       cdb_tag;
    logic [DATA_WIDTH-1:0]     cdb_data;

    modport slave (
        input  enq_valid, enq_store, enq_tag, enq_address, enq_data, flush,
               mem_ready, mem_valid_load, mem_data_addr, mem_load_data,
        output enq_ready, count, mem_load, mem_store, mem_address, mem_store_data,
               cdb_valid, cdb_tag, cdb_data
    );

    modport master (
        output enq_valid, enq_store, enq_tag, enq_address, enq_data, flush,
               mem_ready, mem_valid_load, mem_data_addr, mem_load_data,
        input  enq_ready, count, mem_load, mem_store, mem_address, mem_store_data,
               cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/load_store_queue_fifo.sv
// Circular buffer holding queued memory ops; occupancy tracked by count,
// pointers wrap naturally at DEPTH (power of two). Callers never push when
// full or pop when empty.
module load_store_queue_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        push_data,
    output logic [WIDTH-1:0]        head_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Entry storage write
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; flush discards every stored entry
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: serialises memory ops to the memory unit one at
// a time and broadcasts completions on the CDB.
// Optional macro LSQ_REPORT_EN compiles in a cycle counter and debug trace.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int          CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned TAG_BITS     = 4,
    parameter int unsigned DEPTH        = 8
) (
    input  logic              clock,
    input  logic              reset,
    load_store_queue_if.slave lsq,
    input  logic              report
);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W   = entry_width(DATA_WIDTH, ADDRESS_BITS, TAG_BITS);
    localparam int unsigned ADDR_LSB  = entry_addr_lsb(DATA_WIDTH);
    localparam int unsigned TAG_LSB   = entry_tag_lsb(DATA_WIDTH, ADDRESS_BITS);
    localparam int unsigned STORE_BIT = entry_store_bit(DATA_WIDTH, ADDRESS_BITS, TAG_BITS);

    lsq_state_t                state_q, state_d;
    logic [CNT_W-1:0]          fifo_count;
    logic [ENTRY_W-1:0]        head_entry;
    logic                      push, pop, issue, cdb_fire;
    logic                      head_store;
    logic [TAG_BITS-1:0]       head_tag;
    logic [ADDRESS_BITS-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]     head_data;
    logic                      strobe_out, ld_done, st_done;
    logic                      mem_load_q, mem_store_q, inflight_store_q;
    logic [ADDRESS_BITS-1:0]   mem_address_q;
    logic [DATA_WIDTH-1:0]     mem_store_data_q;
    logic                      cdb_valid_q;
    logic [TAG_BITS-1:0]       cdb_tag_q;
    logic [DATA_WIDTH-1:0]     cdb_data_q;

    assign lsq.enq_ready = (fifo_count < CNT_W'(DEPTH)) && !lsq.flush;
    assign push          = lsq.enq_valid && lsq.enq_ready;

    load_store_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (lsq.flush),
        .push_data ({lsq.enq_store, lsq.enq_tag, lsq.enq_address, lsq.enq_data}),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign head_store = head_entry[STORE_BIT];
    assign head_tag   = head_entry[TAG_LSB +: TAG_BITS];
    assign head_addr  = head_entry[ADDR_LSB +: ADDRESS_BITS];
    assign head_data  = head_entry[0 +: DATA_WIDTH];

    // The memory unit only responds after it has seen the strobe, so the
    // strobe cycle itself never counts as a completion.
    assign strobe_out = mem_load_q || mem_store_q;
    assign ld_done    = !strobe_out && lsq.mem_valid_load && (lsq.mem_data_addr == mem_address_q);
    assign st_done    = !strobe_out && lsq.mem_ready;

    // Next-state, issue and completion decisions for the head entry
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        pop      = 1'b0;
        cdb_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!lsq.flush && (fifo_count != '0) && lsq.mem_ready) begin
                    issue   = 1'b1;
                    state_d = head_store ? WAIT_ST : WAIT_LD;
                end
            end
            WAIT_LD, WAIT_ST: begin
                if ((state_q == WAIT_LD) ? ld_done : st_done) begin
                    state_d  = IDLE;
                    pop      = !lsq.flush;
                    cdb_fire = !lsq.flush;
                end else if (lsq.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The squashed op was already removed by the flush; just
                // wait out the memory unit.
                if (inflight_store_q ? st_done : ld_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request and CDB registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            mem_load_q       <= 1'b0;
            mem_store_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_store_data_q <= '0;
            inflight_store_q <= 1'b0;
            cdb_valid_q      <= 1'b0;
            cdb_tag_q        <= '0;
            cdb_data_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_load_q  <= issue && !head_store;
            mem_store_q <= issue && head_store;
            if (issue) begin
                mem_address_q    <= head_addr;
                mem_store_data_q <= head_store ? head_data : '0;
                inflight_store_q <= head_store;
            end
            cdb_valid_q <= cdb_fire;
            cdb_tag_q   <= cdb_fire ? head_tag : '0;
            cdb_data_q  <= (cdb_fire && (state_q == WAIT_LD)) ? lsq.mem_load_data : '0;
        end
    end

    assign lsq.count          = fifo_count;
    assign lsq.mem_load       = mem_load_q;
    assign lsq.mem_store      = mem_store_q;
    assign lsq.mem_address    = mem_address_q;
    assign lsq.mem_store_data = mem_store_data_q;
    assign lsq.cdb_valid      = cdb_valid_q;
    assign lsq.cdb_tag        = cdb_tag_q;
    assign lsq.cdb_data       = cdb_data_q;

`ifdef LSQ_REPORT_EN
    logic [31:0] cycle_q;

    // Free-running cycle counter used to timestamp reports
    always_ff @(posedge clock) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end

    // Debug trace printed on request
    always_ff @(posedge clock) begin
        if (report) begin
            $display("LSQ core %0d cycle %0d state %s count %0d head tag %0d addr %h ld %b st %b cdb %b tag %0d data %h",
                     CORE, cycle_q, state_q.name(), fifo_count, head_tag, head_addr,
                     mem_load_q, mem_store_q, cdb_valid_q, cdb_tag_q, cdb_data_q);
        end
    end
`else
    logic unused_report;
    assign unused_report = report ^ (CORE != 0);
`endif
endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: transaction-level queue model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_load_store_queue;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 20;
    localparam int unsigned TW    = 4;
    localparam int unsigned DEPTH = 8;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic report = 1'b0;
    always #5 clock = ~clock;

    load_store_queue_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .TAG_BITS(TW), .DEPTH(DEPTH)) bus();

    load_store_queue #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .TAG_BITS(TW), .DEPTH(DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .lsq    (bus),
        .report (report)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } cdb_ev_t;
    cdb_ev_t cdb_log[$];
    int ld_strobes  = 0;
    int last_ld_cyc = 0;

    typedef struct {
        logic          st;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    // Reference model: queued ops in program order plus the one in flight
    op_t           mq[$];
    bit            m_inflight = 0, m_squashed = 0, m_kst = 0;
    logic [AW-1:0] m_iaddr = '0;
    bit            e_ld = 0, e_st = 0, e_cv = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_sdata = '0, e_cdata = '0;
    logic [TW-1:0] e_ctag = '0;
    bit            done, accept, n_ld, n_st, n_cv;
    logic [TW-1:0] n_ctag;
    logic [DW-1:0] n_cdata;
    op_t           nop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model over the next edge
    always @(negedge clock) begin
        cyc++;
        check("count",     64'(bus.count),     64'(mq.size()));
        check("enq_ready", 64'(bus.enq_ready), 64'((mq.size() < DEPTH) && !bus.flush));
        check("mem_load",  64'(bus.mem_load),  64'(e_ld));
        check("mem_store", 64'(bus.mem_store), 64'(e_st));
        if (e_ld || e_st) check("mem_address", 64'(bus.mem_address), 64'(e_addr));
        if (e_st) check("mem_store_data", 64'(bus.mem_store_data), 64'(e_sdata));
        check("cdb_valid", 64'(bus.cdb_valid), 64'(e_cv));
        check("cdb_tag",   64'(bus.cdb_tag),   64'(e_ctag));
        check("cdb_data",  64'(bus.cdb_data),  64'(e_cdata));

        if (bus.cdb_valid) cdb_log.push_back('{cyc, bus.cdb_tag, bus.cdb_data});
        if (bus.mem_load) begin
            ld_strobes++;
            last_ld_cyc = cyc;
        end

        if (reset) begin
            mq.delete();
            m_inflight = 0; m_squashed = 0; m_kst = 0; m_iaddr = '0;
            e_ld = 0; e_st = 0; e_cv = 0; e_ctag = '0; e_cdata = '0;
        end else begin
            done = m_inflight && !(e_ld || e_st) &&
                   (m_kst ? bus.mem_ready : (bus.mem_valid_load && bus.mem_data_addr == m_iaddr));
            accept = bus.enq_valid && (mq.size() < DEPTH) && !bus.flush;
            n_cv    = done && !m_squashed && !bus.flush;
            n_ctag  = n_cv ? mq[0].tag : '0;
            n_cdata = (n_cv && !mq[0].st) ? bus.mem_load_data : '0;
            n_ld = 0; n_st = 0;
            if (!m_inflight && !bus.flush && mq.size() > 0 && bus.mem_ready) begin
                n_ld    = !mq[0].st;
                n_st    = mq[0].st;
                e_addr  = mq[0].addr;
                e_sdata = mq[0].data;
            end
            if (done) begin
                m_inflight = 0;
                if (n_cv) void'(mq.pop_front());
            end
            if (bus.flush) begin
                mq.delete();
                if (m_inflight) m_squashed = 1;
            end
            if (accept) begin
                nop = '{bus.enq_store, bus.enq_tag, bus.enq_address, bus.enq_data};
                mq.push_back(nop);
            end
            if (n_ld || n_st) begin
                m_inflight = 1; m_kst = n_st; m_iaddr = e_addr; m_squashed = 0;
            end
            e_ld = n_ld; e_st = n_st; e_cv = n_cv; e_ctag = n_ctag; e_cdata = n_cdata;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic enq(input bit st, input int tag, input int addr, input logic [DW-1:0] data);
        bus.enq_valid   = 1'b1;
        bus.enq_store   = st;
        bus.enq_tag     = TW'(tag);
        bus.enq_address = AW'(addr);
        bus.enq_data    = data;
        tick();
        bus.enq_valid   = 1'b0;
    endtask

    task automatic mem_return(input int addr, input logic [DW-1:0] data);
        bus.mem_valid_load = 1'b1;
        bus.mem_data_addr  = AW'(addr);
        bus.mem_load_data  = data;
        tick();
        bus.mem_valid_load = 1'b0;
        bus.mem_load_data  = '0;
    endtask

    task automatic wait_strobe(input bit want_store, input string name);
        int k = 0;
        while (!(want_store ? bus.mem_store : bus.mem_load) && k < 40) begin
            tick();
            k++;
        end
        check(name, 64'(want_store ? bus.mem_store : bus.mem_load), 64'd1);
    endtask

    logic [AW-1:0] pend = '0;

    initial begin
        bus.enq_valid = 0; bus.enq_store = 0; bus.enq_tag = '0; bus.enq_address = '0;
        bus.enq_data = '0; bus.flush = 0; bus.mem_ready = 1; bus.mem_valid_load = 0;
        bus.mem_data_addr = '0; bus.mem_load_data = '0;
        ticks(3);
        check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        check("rst_count",     64'(bus.count),     64'd0);
        check("rst_strobes",   64'({bus.mem_load, bus.mem_store}), 64'd0);
        check("rst_cdb",       64'({bus.cdb_valid, bus.cdb_tag, bus.cdb_data}), 64'd0);
        reset = 1'b0;
        tick();

        // Single load, data returned 4 cycles after the request
        cdb_log.delete(); ld_strobes = 0;
        enq(0, 3, 'h00100, '0);
        wait_strobe(0, "t1_issue");
        ticks(4);
        mem_return('h00100, 32'hDEADBEEF);
        ticks(3);
        check("t1_ld_strobes", 64'(ld_strobes), 64'd1);
        check("t1_cdb_count",  64'(cdb_log.size()), 64'd1);
        if (cdb_log.size() == 1) begin
            check("t1_cdb_tag",  64'(cdb_log[0].tag),  64'd3);
            check("t1_cdb_data", 64'(cdb_log[0].data), 64'hDEADBEEF);
        end
        check("t1_count", 64'(bus.count), 64'd0);

        // Store then load to the same address keeps program order
        cdb_log.delete();
        enq(1, 1, 'h00040, 32'h12345678);
        enq(0, 2, 'h00040, '0);
        wait_strobe(0, "t2_ld_issue");
        tick();
        mem_return('h00040, 32'h0BADF00D);
        ticks(3);
        check("t2_cdb_count", 64'(cdb_log.size()), 64'd2);
        if (cdb_log.size() == 2) begin
            check("t2_first_tag",  64'(cdb_log[0].tag),  64'd1);
            check("t2_first_data", 64'(cdb_log[0].data), 64'd0);
            check("t2_second_tag", 64'(cdb_log[1].tag),  64'd2);
            check("t2_second_data", 64'(cdb_log[1].data), 64'h0BADF00D);
            check("t2_ld_after_st", 64'(last_ld_cyc > cdb_log[0].cyc), 64'd1);
        end

        // Fill to full with memory stalled, ninth op dropped, then drain
        cdb_log.delete();
        bus.mem_ready = 0;
        for (int i = 0; i < 8; i++) enq(1, i, 'h00200 + i, DW'(i));
        check("t3_full_ready", 64'(bus.enq_ready), 64'd0);
        enq(1, 8, 'h00208, 32'd8);
        check("t3_full_count", 64'(bus.count), 64'd8);
        bus.mem_ready = 1;
        for (int k = 0; k < 60 && cdb_log.size() < 8; k++) tick();
        ticks(2);
        check("t3_cdb_count", 64'(cdb_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < cdb_log.size(); i++)
            check("t3_cdb_order", 64'(cdb_log[i].tag), 64'(i));

        // Flush with a load in flight and three ops queued behind it
        cdb_log.delete();
        enq(0, 5, 'h00300, '0);
        wait_strobe(0, "t4_issue");
        enq(1, 9, 'h00301, 32'h9);
        enq(1, 10, 'h00302, 32'hA);
        enq(0, 11, 'h00303, '0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t4_count_flushed", 64'(bus.count), 64'd0);
        tick();
        mem_return('h00300, 32'h55AA55AA);
        ticks(3);
        check("t4_no_cdb", 64'(cdb_log.size()), 64'd0);
        enq(1, 6, 'h00310, 32'h66);
        ticks(8);
        check("t4_post_cdb_count", 64'(cdb_log.size()), 64'd1);
        if (cdb_log.size() == 1) check("t4_post_tag", 64'(cdb_log[0].tag), 64'd6);

        // Mismatched return address is ignored
        cdb_log.delete();
        enq(0, 7, 'h00400, '0);
        wait_strobe(0, "t5_issue");
        tick();
        mem_return('h00401, 32'h11111111);
        tick();
        check("t5_count_held", 64'(bus.count), 64'd1);
        check("t5_no_cdb", 64'(cdb_log.size()), 64'd0);
        mem_return('h00400, 32'hCAFEF00D);
        ticks(2);
        check("t5_cdb_count", 64'(cdb_log.size()), 64'd1);
        if (cdb_log.size() == 1) begin
            check("t5_tag",  64'(cdb_log[0].tag),  64'd7);
            check("t5_data", 64'(cdb_log[0].data), 64'hCAFEF00D);
        end

        // Reset while a store waits for the memory unit
        enq(1, 2, 'h00044, 32'h44);
        wait_strobe(1, "t6_issue");
        bus.mem_ready = 0;
        enq(0, 3, 'h00045, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_strobes", 64'({bus.mem_load, bus.mem_store}), 64'd0);
        check("t6_cdb",     64'({bus.cdb_valid, bus.cdb_tag, bus.cdb_data}), 64'd0);
        check("t6_count",   64'(bus.count), 64'd0);
        check("t6_ready",   64'(bus.enq_ready), 64'd1);
        bus.mem_ready = 1;
        enq(0, 4, 'h00050, '0);
        tick();
        check("t6_idle_issue", 64'(bus.mem_load), 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (bus.mem_load) pend = bus.mem_address;
            reset              = ($urandom_range(0, 499) == 0);
            bus.flush          = ($urandom_range(0, 29) == 0);
            bus.enq_valid      = $urandom_range(0, 1) == 1;
            bus.enq_store      = $urandom_range(0, 1) == 1;
            bus.enq_tag        = TW'($urandom);
            bus.enq_address    = AW'($urandom_range(0, 15));
            bus.enq_data       = $urandom;
            bus.mem_ready      = ($urandom_range(0, 3) != 0);
            bus.mem_valid_load = ($urandom_range(0, 2) == 0);
            bus.mem_data_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : pend;
            bus.mem_load_data  = $urandom;
            tick();
        end
        reset = 0; bus.flush = 0; bus.enq_valid = 0; bus.mem_valid_load = 0;
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
